// File: rtl/fw_interface_wb.sv
`default_nettype none
// ============================================================================
// fw_interface_wb : Wishbone B3 classic slave for firmware test-progress reporting
// Define FW_INTERFACE_STRING_PACK_EN for four little-endian bytes per STRING write.
// Revision: 1.0
// ============================================================================
module fw_interface_wb #(
  parameter int ADDR_WIDTH   = 5,
  parameter int PULSE_CYCLES = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  new_report,
  output logic                  new_warning,
  output logic                  new_error,
  output logic                  new_compare,
  output logic [31:0]           report_reg,
  output logic [31:0]           warning_reg,
  output logic [31:0]           error_reg,
  output logic [31:0]           expected_reg,
  output logic [31:0]           measured_reg,
  output logic [5:0]            index,
  output logic [7:0]            data,
  output logic                  write_mem
);

  localparam int            CW         = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES);
  localparam logic [2:0]    A_CTRL     = 3'd0;
  localparam logic [2:0]    A_REPORT   = 3'd1;
  localparam logic [2:0]    A_WARNING  = 3'd2;
  localparam logic [2:0]    A_ERROR    = 3'd3;
  localparam logic [2:0]    A_EXPECTED = 3'd4;
  localparam logic [2:0]    A_MEASURED = 3'd5;
  localparam logic [2:0]    A_STRING   = 3'd6;
  localparam logic [2:0]    A_STATUS   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           ack_q;
  logic [31:0]    dat_q;
  logic [31:0]    report_q, warning_q, error_q, expected_q, measured_q;
  logic [5:0]     ptr_q, ptr_d;
  logic           overflow_q, overflow_d;
  logic           dropped_q;
  logic           pend_q;
  logic [3:0]     fire_q;
  logic [CW-1:0]  cnt_q;

  logic [2:0]     word;
  logic           accept;
  logic           str_wr;
  logic           full_word;
  logic           pulse_on;
  logic           busy;
  logic           emit_done;
  logic [7:0]     cur_byte;
  logic           last_lane;
  logic [31:0]    rd_data;
  logic           unused_adr_bits;

  assign word            = wb_adr_i[4:2];
  assign accept          = wb_cyc_i && wb_stb_i && !ack_q && (state_q == S_IDLE);
  assign str_wr          = accept && wb_we_i && (word == A_STRING);
  assign full_word       = (wb_sel_i == 4'hF);
  assign pulse_on        = (cnt_q != '0);
  assign busy            = pend_q || pulse_on;
  assign unused_adr_bits = ^wb_adr_i;

`ifdef FW_INTERFACE_STRING_PACK_EN
  logic [31:0] buf_q;
  logic [1:0]  lane_q, lane_d;
  assign cur_byte  = buf_q[{lane_q, 3'b000} +: 8];
  assign last_lane = (lane_q == 2'd3);
`else
  logic [7:0]  buf_q;
  assign cur_byte  = buf_q;
  assign last_lane = 1'b1;
`endif

  // String emitter: one byte per EMIT cycle, ack follows the final byte.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    overflow_d = overflow_q;
    write_mem  = 1'b0;
    index      = 6'd0;
    data       = 8'd0;
    emit_done  = 1'b0;
`ifdef FW_INTERFACE_STRING_PACK_EN
    lane_d     = lane_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (str_wr) state_d = S_EMIT;
      end
      S_EMIT: begin
        write_mem = 1'b1;
        index     = ptr_q;
        data      = cur_byte;
        if (cur_byte == 8'd0)      ptr_d      = 6'd0;
        else if (ptr_q == 6'd63)   overflow_d = 1'b1;
        else                       ptr_d      = ptr_q + 6'd1;
        if ((cur_byte == 8'd0) || last_lane) begin
          state_d   = S_ACK;
          emit_done = 1'b1;
`ifdef FW_INTERFACE_STRING_PACK_EN
          lane_d    = 2'd0;
        end else begin
          lane_d    = lane_q + 2'd1;
`endif
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data = 32'd0;
    case (word)
      A_REPORT:   rd_data = report_q;
      A_WARNING:  rd_data = warning_q;
      A_ERROR:    rd_data = error_q;
      A_EXPECTED: rd_data = expected_q;
      A_MEASURED: rd_data = measured_q;
      A_STATUS:   rd_data = {21'd0, busy, dropped_q, overflow_q, 2'b00, ptr_q};
      default:    rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
      report_q   <= 32'd0;
      warning_q  <= 32'd0;
      error_q    <= 32'd0;
      expected_q <= 32'd0;
      measured_q <= 32'd0;
      ptr_q      <= 6'd0;
      overflow_q <= 1'b0;
      dropped_q  <= 1'b0;
      pend_q     <= 1'b0;
      fire_q     <= 4'd0;
      cnt_q      <= '0;
      buf_q      <= '0;
`ifdef FW_INTERFACE_STRING_PACK_EN
      lane_q     <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
      ack_q      <= (accept && !str_wr) || emit_done;
      dat_q      <= (accept && !wb_we_i) ? rd_data : 32'd0;
      pend_q     <= 1'b0;
`ifdef FW_INTERFACE_STRING_PACK_EN
      lane_q     <= lane_d;
      if (str_wr) buf_q <= wb_dat_i;
`else
      if (str_wr) buf_q <= wb_dat_i[7:0];
`endif
      // Counter loads one cycle after the accepting edge so strobes start after ack.
      if (pend_q)        cnt_q <= PULSE_LOAD;
      else if (pulse_on) cnt_q <= cnt_q - CW'(1);
      if (accept && wb_we_i) begin
        case (word)
          A_CTRL: begin
            if (busy) begin
              dropped_q <= 1'b1;
            end else begin
              pend_q <= 1'b1;
              fire_q <= wb_dat_i[3:0];
            end
          end
          A_REPORT:   if (full_word) report_q   <= wb_dat_i;
          A_WARNING:  if (full_word) warning_q  <= wb_dat_i;
          A_ERROR:    if (full_word) error_q    <= wb_dat_i;
          A_EXPECTED: if (full_word) expected_q <= wb_dat_i;
          A_MEASURED: if (full_word) measured_q <= wb_dat_i;
          A_STATUS: begin
            if (wb_dat_i[8]) overflow_q <= 1'b0;
            if (wb_dat_i[9]) dropped_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign wb_dat_o     = dat_q;
  assign wb_ack_o     = ack_q;
  assign new_report   = fire_q[0] && pulse_on;
  assign new_warning  = fire_q[1] && pulse_on;
  assign new_error    = fire_q[2] && pulse_on;
  assign new_compare  = fire_q[3] && pulse_on;
  assign report_reg   = report_q;
  assign warning_reg  = warning_q;
  assign error_reg    = error_q;
  assign expected_reg = expected_q;
  assign measured_reg = measured_q;

endmodule
`default_nettype wire
